// File: rtl/aes_round_sequencer.sv
// AES-128 round sequencer: accepts a block and key, steps an external round
// datapath NR times, then holds the ciphertext until the consumer takes it.
module aes_round_sequencer #(
    parameter int unsigned NR = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic [127:0] dp_state,
    output logic [127:0] dp_key,
    output logic [7:0]   dp_rcon,
    output logic         dp_final,
    input  logic [127:0] dp_state_nxt,
    input  logic [127:0] dp_key_nxt,
    output logic [3:0]   round_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } state_t;

    localparam logic [3:0] LAST = 4'(NR);

    state_t       state;
    state_t       state_nxt;
    logic         accept;
    logic         advance;
    logic [127:0] st_reg;
    logic [127:0] key_reg;
    logic [7:0]   rcon;
    logic [3:0]   round;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                advance = 1'b1;
                if (round == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st_reg  <= '0;
            key_reg <= '0;
            round   <= '0;
            rcon    <= 8'h01;
        end else if (accept) begin
            st_reg  <= data_in ^ key_in;
            key_reg <= key_in;
            round   <= 4'd1;
            rcon    <= 8'h01;
        end else if (advance) begin
            st_reg  <= dp_state_nxt;
            key_reg <= dp_key_nxt;
            rcon    <= xtime(rcon);
            // Counter saturates outside 1..NR so it can never wrap back into range.
            if (round >= 4'd1 && round <= LAST) begin
                round <= round + 4'd1;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == ROUND);
    assign dp_final  = (state == ROUND) && (round == LAST);
    assign data_out  = st_reg;
    assign dp_state  = st_reg;
    assign dp_key    = key_reg;
    assign dp_rcon   = rcon;
    assign round_out = round;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: a reference AES-128 round/key-schedule model
// closes the datapath loop; results are checked against FIPS-197 vectors.
module tb_aes_round_sequencer;

    logic         clock;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic [127:0] dp_state;
    logic [127:0] dp_key;
    logic [7:0]   dp_rcon;
    logic         dp_final;
    logic [127:0] dp_state_nxt;
    logic [127:0] dp_key_nxt;
    logic [3:0]   round_out;
    logic         busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string        name;
        logic [127:0] data;
        logic [127:0] key;
        logic [127:0] expect_ct;
    } vec_t;

    vec_t       vecs [3];
    logic [7:0] rc_exp [10];

    aes_round_sequencer #(.NR(10)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_in      (data_in),
        .key_in       (key_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_out     (data_out),
        .dp_state     (dp_state),
        .dp_key       (dp_key),
        .dp_rcon      (dp_rcon),
        .dp_final     (dp_final),
        .dp_state_nxt (dp_state_nxt),
        .dp_key_nxt   (dp_key_nxt),
        .round_out    (round_out),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference AES model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from the GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r    = 8'h01;
        logic [7:0] base = x;
        logic [7:0] e    = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, base);
            base = gmul(base, base);
        end
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0 = k[127:96];
        logic [31:0] w1 = k[95:64];
        logic [31:0] w2 = k[63:32];
        logic [31:0] w3 = k[31:0];
        logic [31:0] t;
        logic [31:0] n0, n1, n2, n3;
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        t  = t ^ {rc, 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                               input logic fin);
        logic [7:0]   s1 [16];
        logic [7:0]   s2 [16];
        logic [7:0]   s3 [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s1[i] = sbox(st[127 - 8*i -: 8]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s2[r + 4*c] = s1[r + 4*((c + r) % 4)];
        for (int c = 0; c < 4; c++) begin
            if (fin) begin
                for (int r = 0; r < 4; r++) s3[r + 4*c] = s2[r + 4*c];
            end else begin
                s3[4*c]   = gmul(s2[4*c], 8'h02) ^ gmul(s2[4*c+1], 8'h03) ^ s2[4*c+2] ^ s2[4*c+3];
                s3[4*c+1] = s2[4*c] ^ gmul(s2[4*c+1], 8'h02) ^ gmul(s2[4*c+2], 8'h03) ^ s2[4*c+3];
                s3[4*c+2] = s2[4*c] ^ s2[4*c+1] ^ gmul(s2[4*c+2], 8'h02) ^ gmul(s2[4*c+3], 8'h03);
                s3[4*c+3] = gmul(s2[4*c], 8'h03) ^ s2[4*c+1] ^ s2[4*c+2] ^ gmul(s2[4*c+3], 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s3[i];
        return o ^ rk;
    endfunction

    assign dp_key_nxt   = key_expand(dp_key, dp_rcon);
    assign dp_state_nxt = aes_round(dp_state, dp_key_nxt, dp_final);

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs one block from IDLE. hold_done keeps out_ready low for 5 DONE cycles,
    // disturb scrambles in_valid/data_in/key_in while the block is in flight.
    task automatic run_block(input vec_t v, input bit hold_done, input bit disturb,
                             input bit chk_rounds);
        int cnt;
        chk({v.name, "_in_ready"}, 128'(in_ready), 128'(1));
        data_in   = v.data;
        key_in    = v.key;
        in_valid  = 1'b1;
        out_ready = !hold_done;
        tick();
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 40) begin
            if (chk_rounds && cnt <= 10) begin
                chk({v.name, "_round"}, 128'(round_out), 128'(cnt));
                chk({v.name, "_rcon"}, 128'(dp_rcon), 128'(rc_exp[cnt-1]));
                chk({v.name, "_final"}, 128'(dp_final), 128'(cnt == 10));
                chk({v.name, "_busy"}, 128'(busy), 128'(1));
            end
            if (disturb) begin
                in_valid = cnt[0];
                data_in  = {$urandom, $urandom, $urandom, $urandom};
                key_in   = {$urandom, $urandom, $urandom, $urandom};
            end
            tick();
            cnt++;
        end
        in_valid = 1'b0;
        chk({v.name, "_latency"}, 128'(cnt), 128'(11));
        chk({v.name, "_data"}, data_out, v.expect_ct);
        chk({v.name, "_done_ready"}, 128'(in_ready), 128'(0));
        chk({v.name, "_done_busy"}, 128'(busy), 128'(0));
        if (hold_done) begin
            for (int i = 0; i < 5; i++) begin
                in_valid = 1'b1;
                tick();
                chk("hold_valid", 128'(out_valid), 128'(1));
                chk("hold_data", data_out, v.expect_ct);
                chk("hold_ready", 128'(in_ready), 128'(0));
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("release_ready", 128'(in_ready), 128'(1));
            chk("release_busy", 128'(busy), 128'(0));
            chk("release_valid", 128'(out_valid), 128'(0));
            in_valid = 1'b0;
        end else begin
            tick();
            chk({v.name, "_idle_ready"}, 128'(in_ready), 128'(1));
            chk({v.name, "_idle_valid"}, 128'(out_valid), 128'(0));
        end
    endtask

    initial begin
        int waitc;
        int blk_in;
        int blk_out;
        int last_rdy;
        int cyc;

        vecs[0] = '{"c1", 128'h00112233445566778899aabbccddeeff,
                    128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{"fipsb", 128'h3243f6a8885a308d313198a2e0370734,
                    128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{"zero", 128'h0, 128'h0,
                    128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        rc_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        key_in    = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_data_out", data_out, 128'h0);
        chk("rst_final", 128'(dp_final), 128'(0));
        chk("rst_round", 128'(round_out), 128'(0));
        chk("rst_rcon", 128'(dp_rcon), 128'(8'h01));

        for (int i = 0; i < 3; i++) run_block(vecs[i], 1'b0, 1'b0, i == 1);

        run_block(vecs[0], 1'b1, 1'b0, 1'b0);
        run_block(vecs[1], 1'b0, 1'b1, 1'b0);

        // reset in the middle of round 5, then a clean block
        data_in  = vecs[0].data;
        key_in   = vecs[0].key;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        waitc = 0;
        while (round_out != 4'd5 && waitc < 20) begin
            tick();
            waitc++;
        end
        chk("mid_reach_r5", 128'(round_out), 128'(5));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_ready", 128'(in_ready), 128'(1));
        chk("mid_rst_round", 128'(round_out), 128'(0));
        chk("mid_rst_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        run_block(vecs[0], 1'b0, 1'b0, 1'b0);

        // back-to-back stream with both handshakes held high
        blk_in   = 0;
        blk_out  = 0;
        last_rdy = -1;
        cyc      = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (blk_out < 3 && cyc < 100) begin
            if (in_ready) begin
                if (last_rdy >= 0) chk("b2b_gap", 128'(cyc - last_rdy), 128'(12));
                last_rdy = cyc;
                if (blk_in < 3) begin
                    data_in = vecs[blk_in].data;
                    key_in  = vecs[blk_in].key;
                    blk_in++;
                end
            end
            if (out_valid) begin
                chk("b2b_data", data_out, vecs[blk_out].expect_ct);
                blk_out++;
                if (blk_out == 3) in_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        chk("b2b_count", 128'(blk_out), 128'(3));
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
